// File: rtl/mcs4_pkg.sv
`default_nettype none
// ============================================================================
// Package : mcs4
// Purpose : Shared types and constants for the MCS-4 core and bus controller.
//           Instruction-cycle phases, I/O-group OPA codes, RAM selection
//           record, memory latencies, and a few decode helpers.
// Revision: 1.0  initial release
// ============================================================================
package mcs4;

    // UNSYNC is the power-up / lost-alignment state; the rest are the eight
    // clock phases of one instruction cycle.
    typedef enum logic [3:0] {
        UNSYNC = 4'd0,
        A1     = 4'd1,
        A2     = 4'd2,
        A3     = 4'd3,
        M1     = 4'd4,
        M2     = 4'd5,
        X1     = 4'd6,
        X2     = 4'd7,
        X3     = 4'd8
    } instr_cyc_t;

    // OPA field of the I/O and RAM instruction group (OPR = 0xE).
    typedef enum logic [3:0] {
        OP_WRM = 4'h0, OP_WMP = 4'h1, OP_WRR = 4'h2, OP_WPM = 4'h3,
        OP_WR0 = 4'h4, OP_WR1 = 4'h5, OP_WR2 = 4'h6, OP_WR3 = 4'h7,
        OP_SBM = 4'h8, OP_RDM = 4'h9, OP_RDR = 4'hA, OP_ADM = 4'hB,
        OP_RD0 = 4'hC, OP_RD1 = 4'hD, OP_RD2 = 4'hE, OP_RD3 = 4'hF
    } ioram_opa_t;

    // RAM character selection latched by SRC (bank comes from CM-RAM).
    typedef struct packed {
        logic [1:0] bank;
        logic [1:0] chip;
        logic [1:0] reg_idx;
        logic [3:0] char_idx;
    } ram_sel_t;

    localparam logic [3:0] Rom_latency = 4'd1;
    localparam logic [3:0] Ram_latency = 4'd1;

    // Status accesses (WR0-3, RD0-3) are exactly the OPA codes with bit 2 set.
    function automatic logic op_is_stat(input ioram_opa_t op);
        logic [3:0] b;
        b = op;
        return b[2];
    endfunction

    function automatic logic op_is_ram_read(input ioram_opa_t op);
        logic [3:0] b;
        b = op;
        return b[3] && (op != OP_RDR);
    endfunction

    // Address presented to RAM: status accesses replace the character index
    // with {2'b00, status index}.
    function automatic logic [9:0] ram_word(input ram_sel_t sel, input ioram_opa_t op);
        logic [3:0] b;
        b = op;
        if (op_is_stat(op)) begin
            return {sel.bank, sel.chip, sel.reg_idx, 2'b00, b[1:0]};
        end
        return sel;
    endfunction

    // Bank number of the lowest asserted CM-RAM line.
    function automatic logic [1:0] lowest_bank(input logic [3:0] cm);
        if (cm[0])      return 2'd0;
        else if (cm[1]) return 2'd1;
        else if (cm[2]) return 2'd2;
        return 2'd3;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcs4_phase_track.sv
`default_nettype none
// ============================================================================
// Module  : mcs4_phase_track
// Purpose : Follows the 4004 eight-phase instruction cycle from SYNC and flags
//           any misalignment.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           sync          - core SYNC, expected high during X3
//           phase         - current phase (UNSYNC until first SYNC)
//           sync_err      - one-cycle pulse in the cycle SYNC is misaligned
// Revision: 1.0  initial release
// ============================================================================
module mcs4_phase_track
    import mcs4::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sync,
    output instr_cyc_t phase,
    output logic       sync_err
);

    instr_cyc_t state;
    instr_cyc_t state_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UNSYNC;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sync_err = 1'b0;
        case (state)
            UNSYNC: begin
                if (sync) state_nx = A1;
            end
            X3: begin
                if (sync) begin
                    state_nx = A1;
                end else begin
                    state_nx = UNSYNC;
                    sync_err = 1'b1;
                end
            end
            default: begin
                if (sync) begin
                    // Early SYNC: trust the core and realign on it.
                    state_nx = A1;
                    sync_err = 1'b1;
                end else begin
                    state_nx = instr_cyc_t'(state + 4'd1);
                end
            end
        endcase
        if (rst) sync_err = 1'b0;
    end

    assign phase = state;

endmodule
`default_nettype wire

// File: rtl/mcs4_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module  : mcs4_bus_ctl
// Purpose : Bus controller between the i4004 core and synchronous ROM/RAM.
//           Fetches ROM bytes at M1/M2, latches SRC selections and executes
//           I/O-group instructions against RAM characters, RAM status and the
//           RAM/ROM output ports.
// Ports   : clk, rst                    - clock, synchronous active-high reset
//           sync, cm_rom, cm_ram        - core control lines
//           cpu_dout / cpu_din          - core data bus out / in
//           rom_en, rom_addr, rom_data  - ROM read port (1-cycle latency)
//           ram_re, ram_we, ram_addr,
//           ram_stat, ram_wdata,
//           ram_rdata                   - RAM port (1-cycle read latency)
//           ram_port_wr, rom_port_wr,
//           port_sel, port_wdata,
//           rom_port_rdata              - output/input ports
//           sync_err                    - phase misalignment pulse
// Revision: 1.0  initial release
// ============================================================================
module mcs4_bus_ctl
    import mcs4::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        sync,
    input  logic        cm_rom,
    input  logic [3:0]  cm_ram,
    input  logic [3:0]  cpu_dout,
    output logic [3:0]  cpu_din,
    output logic        rom_en,
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        ram_re,
    output logic        ram_we,
    output logic [9:0]  ram_addr,
    output logic        ram_stat,
    output logic [3:0]  ram_wdata,
    input  logic [3:0]  ram_rdata,
    output logic        ram_port_wr,
    output logic        rom_port_wr,
    output logic [3:0]  port_sel,
    output logic [3:0]  port_wdata,
    input  logic [3:0]  rom_port_rdata,
    output logic        sync_err
);

    // Phases in which synchronous memory data becomes valid.
    localparam instr_cyc_t ROM_DATA_PHASE = instr_cyc_t'(A3 + Rom_latency);
    localparam instr_cyc_t RAM_DATA_PHASE = instr_cyc_t'(X1 + Ram_latency);

    instr_cyc_t phase;
    logic [7:0] addr_lo;
    logic [3:0] fetch_opa;   // high nibble already went to the core in M1
    logic       io_pend;
    ioram_opa_t io_op;
    logic       src_pend;
    ram_sel_t   sel;
    logic [3:0] rom_chip;
    logic [3:0] wr_data;

    mcs4_phase_track u_phase (
        .clk      (clk),
        .rst      (rst),
        .sync     (sync),
        .phase    (phase),
        .sync_err (sync_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_lo   <= 8'h00;
            fetch_opa <= 4'h0;
            io_pend   <= 1'b0;
            io_op     <= OP_WRM;
            src_pend  <= 1'b0;
            sel       <= '0;
            rom_chip  <= 4'h0;
            wr_data   <= 4'h0;
        end else begin
            case (phase)
                A1: begin
                    addr_lo[3:0] <= cpu_dout;
                    // A resync straight to A1 skips X3, so drop leftovers here.
                    io_pend      <= 1'b0;
                    src_pend     <= 1'b0;
                end
                A2: addr_lo[7:4] <= cpu_dout;
                ROM_DATA_PHASE: fetch_opa <= rom_data[3:0];
                M2: begin
                    if (cm_rom) begin
                        io_pend <= 1'b1;
                        io_op   <= ioram_opa_t'(fetch_opa);
                    end
                end
                X2: begin
                    if (io_pend) begin
                        wr_data <= cpu_dout;
                    end else if (cm_rom) begin
                        sel.chip    <= cpu_dout[3:2];
                        sel.reg_idx <= cpu_dout[1:0];
                        rom_chip    <= cpu_dout;
                        src_pend    <= 1'b1;
                        if (cm_ram != 4'h0) sel.bank <= lowest_bank(cm_ram);
                    end
                end
                X3: begin
                    io_pend <= 1'b0;
                    if (src_pend) begin
                        sel.char_idx <= cpu_dout;
                        src_pend     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cpu_din     = 4'h0;
        rom_en      = 1'b0;
        rom_addr    = 12'h000;
        ram_re      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = 10'h000;
        ram_stat    = 1'b0;
        ram_wdata   = 4'h0;
        ram_port_wr = 1'b0;
        rom_port_wr = 1'b0;
        port_sel    = 4'h0;
        port_wdata  = 4'h0;
        case (phase)
            A3: begin
                rom_en   = 1'b1;
                rom_addr = {cpu_dout, addr_lo};
            end
            ROM_DATA_PHASE: cpu_din = rom_data[7:4];
            M2: cpu_din = fetch_opa;
            X1: begin
                if (io_pend && op_is_ram_read(io_op)) begin
                    ram_re   = 1'b1;
                    ram_addr = ram_word(sel, io_op);
                    ram_stat = op_is_stat(io_op);
                end
            end
            RAM_DATA_PHASE: begin
                if (io_pend) begin
                    if (op_is_ram_read(io_op)) begin
                        cpu_din = ram_rdata;
                    end else if (io_op == OP_RDR) begin
                        port_sel = rom_chip;
                        cpu_din  = rom_port_rdata;
                    end
                end
            end
            X3: begin
                if (io_pend) begin
                    case (io_op)
                        OP_WRM, OP_WR0, OP_WR1, OP_WR2, OP_WR3: begin
                            ram_we    = 1'b1;
                            ram_addr  = ram_word(sel, io_op);
                            ram_stat  = op_is_stat(io_op);
                            ram_wdata = wr_data;
                        end
                        OP_WMP: begin
                            ram_port_wr = 1'b1;
                            port_sel    = {sel.bank, sel.chip};
                            port_wdata  = wr_data;
                        end
                        OP_WRR: begin
                            rom_port_wr = 1'b1;
                            port_sel    = rom_chip;
                            port_wdata  = wr_data;
                        end
                        default: ;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mcs4_bus_ctl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mcs4_bus_ctl
// Purpose : Self-checking bench for mcs4_bus_ctl. Directed instruction cycles
//           push expected strobes and cpu_din values into queues; a monitor
//           on the falling edge pops and compares them.
// Revision: 1.0  initial release
// ============================================================================
module tb_mcs4_bus_ctl;

    localparam int K_ROM   = 0;
    localparam int K_RE    = 1;
    localparam int K_WE    = 2;
    localparam int K_RPORT = 3;
    localparam int K_OPORT = 4;
    localparam int K_SERR  = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        sync;
    logic        cm_rom;
    logic [3:0]  cm_ram;
    logic [3:0]  cpu_dout;
    logic [3:0]  cpu_din;
    logic        rom_en;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        ram_re;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic        ram_stat;
    logic [3:0]  ram_wdata;
    logic [3:0]  ram_rdata = 4'h0;
    logic        ram_port_wr;
    logic        rom_port_wr;
    logic [3:0]  port_sel;
    logic [3:0]  port_wdata;
    logic [3:0]  rom_port_rdata;
    logic        sync_err;

    always #5 clk = ~clk;

    mcs4_bus_ctl dut (
        .clk            (clk),
        .rst            (rst),
        .sync           (sync),
        .cm_rom         (cm_rom),
        .cm_ram         (cm_ram),
        .cpu_dout       (cpu_dout),
        .cpu_din        (cpu_din),
        .rom_en         (rom_en),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .ram_re         (ram_re),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_stat       (ram_stat),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .ram_port_wr    (ram_port_wr),
        .rom_port_wr    (rom_port_wr),
        .port_sel       (port_sel),
        .port_wdata     (port_wdata),
        .rom_port_rdata (rom_port_rdata),
        .sync_err       (sync_err)
    );

    // Memory models: one-cycle read latency.
    logic [7:0] rom_mem  [0:4095];
    logic [3:0] char_mem [0:1023];
    logic [3:0] stat_mem [0:1023];

    always @(posedge clk) begin
        rom_data <= rom_en ? rom_mem[rom_addr] : 8'h00;
        if (ram_re) ram_rdata <= ram_stat ? stat_mem[ram_addr] : char_mem[ram_addr];
        if (ram_we && !ram_stat) char_mem[ram_addr] <= ram_wdata;
    end

    assign rom_port_rdata = port_sel ^ 4'hA;

    // Scoreboard.
    typedef struct {
        string       name;
        int          kind;
        logic [11:0] addr;
        logic [3:0]  data;
    } ev_t;

    typedef struct {
        string      name;
        logic [3:0] exp;
    } din_t;

    ev_t  ev_q[$];
    din_t din_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic mon_en   = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endfunction

    ev_t        m_e;
    din_t       m_d;
    logic [5:0] m_stb;
    logic [11:0] m_a;
    logic [3:0] m_dat;

    always @(negedge clk) begin
        if (mon_en) begin
            if (din_q.size() > 0) begin
                m_d = din_q.pop_front();
                chk(m_d.name, 32'(cpu_din), 32'(m_d.exp));
            end
            m_stb = {sync_err, rom_port_wr, ram_port_wr, ram_we, ram_re, rom_en};
            for (int k = 0; k < 6; k++) begin
                if (m_stb[k]) begin
                    case (k)
                        K_ROM:            begin m_a = rom_addr;                  m_dat = 4'h0;       end
                        K_RE:             begin m_a = {ram_stat, 1'b0, ram_addr}; m_dat = 4'h0;       end
                        K_WE:             begin m_a = {ram_stat, 1'b0, ram_addr}; m_dat = ram_wdata;  end
                        K_RPORT, K_OPORT: begin m_a = {8'h00, port_sel};          m_dat = port_wdata; end
                        default:          begin m_a = 12'h000;                    m_dat = 4'h0;       end
                    endcase
                    if (ev_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_strobe: kind %0d addr %0h data %0h seen, none required",
                                 k, m_a, m_dat);
                    end else begin
                        m_e = ev_q.pop_front();
                        chk({m_e.name, " kind"}, 32'(k), 32'(m_e.kind));
                        chk({m_e.name, " addr"}, 32'(m_a), 32'(m_e.addr));
                        chk({m_e.name, " data"}, 32'(m_dat), 32'(m_e.data));
                    end
                end
            end
        end
    end

    // Stimulus helpers.
    task automatic push_ev(input string name, input int kind, input logic [11:0] a, input logic [3:0] d);
        ev_t e;
        e.name = name;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        ev_q.push_back(e);
    endtask

    task automatic push_din(input string name, input logic [3:0] v);
        din_t d;
        d.name = name;
        d.exp  = v;
        din_q.push_back(d);
    endtask

    task automatic step(input logic s, input logic cr, input logic [3:0] cram, input logic [3:0] dout);
        sync     = s;
        cm_rom   = cr;
        cm_ram   = cram;
        cpu_dout = dout;
        @(posedge clk);
        #1;
    endtask

    // mode 0: normal cycle, 1: SYNC raised in M2 (cycle ends there),
    // 2: SYNC withheld in X3.
    task automatic icycle(input string nm, input logic [11:0] pc,
                          input logic [3:0] m1, input logic [3:0] m2,
                          input logic io, input logic src, input logic [3:0] cram,
                          input logic [3:0] x2, input logic [3:0] x3,
                          input logic chk_x2, input logic [3:0] x2_din,
                          input logic has_ev, input int ek, input logic [11:0] ea,
                          input logic [3:0] ed, input int mode);
        step(1'b0, 1'b0, 4'h0, pc[3:0]);
        step(1'b0, 1'b0, 4'h0, pc[7:4]);
        push_ev({nm, " rom_en"}, K_ROM, pc, 4'h0);
        if (has_ev) push_ev({nm, " io"}, ek, ea, ed);
        if (mode != 0) push_ev({nm, " sync_err"}, K_SERR, 12'h000, 4'h0);
        step(1'b0, 1'b0, 4'h0, pc[11:8]);
        push_din({nm, " din_M1"}, m1);
        step(1'b0, 1'b0, 4'h0, 4'h0);
        push_din({nm, " din_M2"}, m2);
        if (mode == 1) begin
            step(1'b1, 1'b0, 4'h0, 4'h0);
            return;
        end
        step(1'b0, io, 4'h0, 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h0);
        if (chk_x2) push_din({nm, " din_X2"}, x2_din);
        step(1'b0, src, cram, x2);
        step(mode != 2, 1'b0, 4'h0, x3);
    endtask

    initial begin
        rst = 1'b1; sync = 1'b0; cm_rom = 1'b0; cm_ram = 4'h0; cpu_dout = 4'h0;
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'h00;
        for (int i = 0; i < 1024; i++) stat_mem[i] = 4'h0;
        rom_mem[12'h123] = 8'hD5;  // plain fetch
        rom_mem[12'h124] = 8'h25;  // SRC
        rom_mem[12'h125] = 8'hE0;  // WRM
        rom_mem[12'h126] = 8'hEE;  // RD2
        rom_mem[12'h127] = 8'hE9;  // RDM
        rom_mem[12'h128] = 8'h23;  // SRC
        rom_mem[12'h129] = 8'hE2;  // WRR
        rom_mem[12'h12A] = 8'hE1;  // WMP
        rom_mem[12'h12B] = 8'hEA;  // RDR
        rom_mem[12'h12C] = 8'hE5;  // WR1
        rom_mem[12'h12D] = 8'h61;
        rom_mem[12'h130] = 8'h4B;
        rom_mem[12'h131] = 8'h98;
        stat_mem[10'h252] = 4'h9;  // bank 2, chip 1, reg 1, status 2

        repeat (3) @(posedge clk);
        #1;
        chk("reset strobes", 32'({sync_err, rom_port_wr, ram_port_wr, ram_we, ram_re, rom_en}), 32'd0);
        chk("reset cpu_din", 32'(cpu_din), 32'd0);
        chk("reset buses", 32'({rom_addr, ram_addr, ram_stat, port_sel}), 32'd0);
        chk("reset wdata", 32'({ram_wdata, port_wdata}), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Unsynchronised: busy inputs, silent outputs.
        push_din("unsync din 0", 4'h0);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        push_din("unsync din 1", 4'h0);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        push_din("sync din", 4'h0);
        step(1'b1, 1'b0, 4'h0, 4'h0);

        //     name    pc       m1    m2    io    src   cram  x2    x3   chkx2 x2din ev  kind     addr     data mode
        icycle("fetch", 12'h123, 4'hD, 4'h5, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, K_ROM, 12'h000, 4'h0, 0);
        icycle("src1",  12'h124, 4'h2, 4'h5, 1'b0, 1'b1, 4'h4, 4'h5, 4'hA, 1'b1, 4'h0, 1'b0, K_ROM, 12'h000, 4'h0, 0);
        icycle("wrm",   12'h125, 4'hE, 4'h0, 1'b1, 1'b0, 4'h0, 4'h7, 4'h0, 1'b1, 4'h0, 1'b1, K_WE,  12'h25A, 4'h7, 0);
        icycle("rd2",   12'h126, 4'hE, 4'hE, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h9, 1'b1, K_RE,  12'hA52, 4'h0, 0);
        icycle("rdm",   12'h127, 4'hE, 4'h9, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h7, 1'b1, K_RE,  12'h25A, 4'h0, 0);
        icycle("src2",  12'h128, 4'h2, 4'h3, 1'b0, 1'b1, 4'h0, 4'h3, 4'h0, 1'b0, 4'h0, 1'b0, K_ROM, 12'h000, 4'h0, 0);
        icycle("wrr",   12'h129, 4'hE, 4'h2, 1'b1, 1'b0, 4'h0, 4'hC, 4'h0, 1'b0, 4'h0, 1'b1, K_OPORT, 12'h003, 4'hC, 0);
        icycle("wmp",   12'h12A, 4'hE, 4'h1, 1'b1, 1'b0, 4'h0, 4'h4, 4'h0, 1'b0, 4'h0, 1'b1, K_RPORT, 12'h008, 4'h4, 0);
        icycle("rdr",   12'h12B, 4'hE, 4'hA, 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h9, 1'b0, K_ROM, 12'h000, 4'h0, 0);
        icycle("wr1",   12'h12C, 4'hE, 4'h5, 1'b1, 1'b0, 4'h0, 4'h6, 4'h0, 1'b0, 4'h0, 1'b1, K_WE,  12'hA31, 4'h6, 0);
        icycle("early", 12'h12D, 4'h6, 4'h1, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, K_ROM, 12'h000, 4'h0, 1);
        icycle("resync",12'h130, 4'h4, 4'hB, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 4'h0, 1'b0, K_ROM, 12'h000, 4'h0, 0);
        icycle("drop",  12'h131, 4'h9, 4'h8, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, K_ROM, 12'h000, 4'h0, 2);

        // Back in UNSYNC: nothing may fire, cpu_din stays 0.
        push_din("lost din 0", 4'h0);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        push_din("lost din 1", 4'h0);
        step(1'b0, 1'b1, 4'hF, 4'hF);
        push_din("lost din 2", 4'h0);
        step(1'b0, 1'b0, 4'h0, 4'h5);

        chk("events outstanding", 32'(ev_q.size()), 32'd0);
        chk("din checks outstanding", 32'(din_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
